// File: rtl/uart_pkg.sv
// Shared constants and enums for the UART command-line decoder.
package uart_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_T  = 8'h54;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_CLEAR = 3'd3;
  localparam logic [2:0] CMD_SET   = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_DISCARD} state_e;
  typedef enum logic [1:0] {CLS_LETTER, CLS_DIGIT, CLS_TERM, CLS_OTHER} class_e;
endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-strobe input and command/error output bundle of the decoder.
interface uart_cmd_decoder_if #(parameter int ARG_W = 14);
  logic [7:0]       i_rx_data;
  logic             i_rx_done;
  logic [2:0]       o_cmd;
  logic [ARG_W-1:0] o_arg;
  logic             o_cmd_valid;
  logic             o_cmd_err;

  modport master (output i_rx_data, i_rx_done,
                  input  o_cmd, o_arg, o_cmd_valid, o_cmd_err);
  modport slave  (input  i_rx_data, i_rx_done,
                  output o_cmd, o_arg, o_cmd_valid, o_cmd_err);
endinterface

// File: rtl/uart_ascii_class.sv
// Combinational byte classifier: class, opcode for command letters, digit value.
module uart_ascii_class
  import uart_pkg::*;
(
  input  logic [7:0] data_i,
  output class_e     cls_o,
  output logic [2:0] op_o,
  output logic [3:0] dig_o
);
  logic [7:0] up;

  // Clearing bit 5 folds lowercase command letters onto uppercase.
  assign up = data_i & 8'hDF;

  always_comb begin
    cls_o = CLS_OTHER;
    op_o  = CMD_NONE;
    dig_o = data_i[3:0];
    if (data_i >= ASCII_0 && data_i <= ASCII_9) begin
      cls_o = CLS_DIGIT;
    end else if (data_i == ASCII_CR || data_i == ASCII_LF) begin
      cls_o = CLS_TERM;
    end else begin
      case (up)
        ASCII_R: begin cls_o = CLS_LETTER; op_o = CMD_RUN;   end
        ASCII_S: begin cls_o = CLS_LETTER; op_o = CMD_STOP;  end
        ASCII_C: begin cls_o = CLS_LETTER; op_o = CMD_CLEAR; end
        ASCII_T: begin cls_o = CLS_LETTER; op_o = CMD_SET;   end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles "<letter>[digits]<CR|LF>" lines from UART bytes into opcode/argument
// pulses; malformed lines give a single error pulse.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int ARG_W      = 14
) (
  input  logic clk,
  input  logic rst,
  uart_cmd_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  class_e           cls;
  logic [2:0]       op;
  logic [3:0]       dig;

  state_e           state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic [ARG_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             legal;

  uart_ascii_class u_cls (
    .data_i (bus.i_rx_data),
    .cls_o  (cls),
    .op_o   (op),
    .dig_o  (dig)
  );

  // SET requires an argument; the other commands must not carry one.
  assign legal = (pend_q == CMD_SET) ? (cnt_q != CNT_W'(0)) : (cnt_q == CNT_W'(0));

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.i_rx_done) begin
      case (state_q)
        ST_IDLE: begin
          if (cls == CLS_LETTER) begin
            pend_d  = op;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_ARG;
          end else if (cls != CLS_TERM) begin
            state_d = ST_DISCARD;
          end
        end
        ST_ARG: begin
          if (cls == CLS_DIGIT) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              acc_d = (acc_q << 3) + (acc_q << 1) + {{(ARG_W-4){1'b0}}, dig};
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = ST_DISCARD;
            end
          end else if (cls == CLS_TERM) begin
            state_d = ST_IDLE;
            if (legal) begin
              cmd_d = pend_q;
              arg_d = acc_q;
              vld_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (cls == CLS_TERM) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= CMD_NONE;
      acc_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= CMD_NONE;
      arg_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_cmd       = cmd_q;
  assign bus.o_arg       = arg_q;
  assign bus.o_cmd_valid = vld_q;
  assign bus.o_cmd_err   = err_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: each terminator pushes the expected pulse, the monitor pops on pulses.
module tb_uart_cmd_decoder;
  localparam int ARG_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic             is_err;
    logic [2:0]       cmd;
    logic [ARG_W-1:0] arg;
    int               due;
  } exp_t;
  exp_t sb[$];

  uart_cmd_decoder_if #(.ARG_W(ARG_W)) ifc ();

  uart_cmd_decoder #(.MAX_DIGITS(4), .ARG_W(ARG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.i_rx_data = b;
    ifc.i_rx_done = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ifc.i_rx_done = 1'b0;
    end
  endtask

  // kind: 0 no pulse, 1 valid, 2 error; cmd/arg are the outputs expected at the pulse.
  task automatic send_line(input string body, input logic [7:0] term, input int kind,
                           input logic [2:0] cmd, input logic [ARG_W-1:0] arg);
    exp_t e;
    for (int i = 0; i < body.len(); i++) send_byte(body[i]);
    send_byte(term);
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.cmd    = cmd;
      e.arg    = arg;
      e.due    = cyc + 1;
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.o_cmd_valid && ifc.o_cmd_err) chk("both_pulses", 32'd1, 32'd0);
        if (sb.size() != 0 && cyc > sb[0].due) begin
          chk("missing_pulse", 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end
        if (ifc.o_cmd_valid || ifc.o_cmd_err) begin
          if (sb.size() == 0) begin
            chk("spurious_pulse", {31'd0, ifc.o_cmd_err}, 32'd2);
          end else begin
            e = sb.pop_front();
            chk("pulse_kind", {31'd0, ifc.o_cmd_err}, {31'd0, e.is_err});
            chk("cmd",        32'(ifc.o_cmd), 32'(e.cmd));
            chk("arg",        32'(ifc.o_arg), 32'(e.arg));
            chk("latency",    32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  initial begin
    ifc.i_rx_data = 8'h00;
    ifc.i_rx_done = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_cmd", 32'(ifc.o_cmd), 32'd0);
    chk("rst_arg", 32'(ifc.o_arg), 32'd0);
    chk("rst_vld", {31'd0, ifc.o_cmd_valid}, 32'd0);
    chk("rst_err", {31'd0, ifc.o_cmd_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    send_line("T123", 8'h0D, 1, 3'd4, 14'd123);
    idle(3);
    // back-to-back lines, lowercase letters
    send_line("r", 8'h0A, 1, 3'd1, 14'd0);
    send_line("s", 8'h0D, 1, 3'd2, 14'd0);
    idle(3);
    send_line("T12345", 8'h0D, 2, 3'd2, 14'd0);
    send_line("T",      8'h0D, 2, 3'd2, 14'd0);
    send_line("C5",     8'h0D, 2, 3'd2, 14'd0);
    send_line("X9",     8'h0D, 2, 3'd2, 14'd0);
    send_line("",       8'h0D, 0, 3'd0, 14'd0);
    send_line("",       8'h0D, 0, 3'd0, 14'd0);
    send_line("RX",     8'h0A, 2, 3'd2, 14'd0);
    idle(3);
    send_line("T9999", 8'h0D, 1, 3'd4, 14'd9999);
    send_line("T0",    8'h0D, 1, 3'd4, 14'd0);
    send_line("t7",    8'h0A, 1, 3'd4, 14'd7);
    // gap cycles between the letter and its terminator
    send_byte(8'h63);
    idle(3);
    send_line("", 8'h0D, 1, 3'd3, 14'd0);
    idle(3);
    chk("hold_cmd", 32'(ifc.o_cmd), 32'd3);

    send_byte(8'h54); send_byte(8'h34); send_byte(8'h35);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd", 32'(ifc.o_cmd), 32'd0);
    chk("midrst_arg", 32'(ifc.o_arg), 32'd0);
    idle(2);
    rst = 1'b0;
    send_line("", 8'h0D, 0, 3'd0, 14'd0);
    idle(3);
    chk("post_rst_cmd", 32'(ifc.o_cmd), 32'd0);
    chk("post_rst_arg", 32'(ifc.o_arg), 32'd0);
    send_line("R", 8'h0D, 1, 3'd1, 14'd0);
    idle(5);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
